// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and default widths.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if non-negative.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {p, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // A negative trial keeps the shifted value; its top bit is then always 0
    // because the partial remainder entering the step is below the divisor.
    assign p_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/divide_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and a one-cycle divide-by-zero shortcut.
module divide_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             zero_pend;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             accept_run;
    logic             accept_zero;
    logic             last_step;
    logic             busy_next;
    logic             done_next;

    // The cycle after a divide-by-zero capture is not RUN, but it must not
    // accept another request before the result is published.
    assign accept      = start && (state != RUN) && !zero_pend;
    assign accept_run  = accept && (divisor != '0);
    assign accept_zero = accept && (divisor == '0);
    assign last_step   = (state == RUN) && (count == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p      (p),
        .q      (q),
        .divisor(dvsr),
        .p_next (p_next),
        .q_next (q_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (zero_pend)       next_state = DONE;
                else if (accept_run) next_state = RUN;
                else                 next_state = IDLE;
            end
            RUN:     if (last_step) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state, so they line up
    // with the state register and never depend combinationally on inputs.
    always_comb begin
        busy_next = (next_state == RUN);
        done_next = (next_state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_pend   <= 1'b0;
            p           <= '0;
            q           <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            zero_pend <= accept_zero;
            if (accept) begin
                p     <= '0;
                q     <= dividend;
                dvsr  <= divisor;
                count <= '0;
            end else if (state == RUN) begin
                p     <= p_next;
                q     <= q_next;
                count <= count + 1'b1;
                if (last_step) begin
                    quotient    <= q_next;
                    remainder   <= p_next;
                    div_by_zero <= 1'b0;
                end
            end
            if (zero_pend) begin
                quotient    <= '1;
                remainder   <= q;
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule
